// File: rtl/traffic_sequencer.sv
// Timing-state sequencer feeding the traffic-light decoder: tick prescaler, per-state dwell,
// pedestrian latch, fault all-red. Optional preempt input compiled in with TRAFFIC_PREEMPT_EN.
module traffic_sequencer #(
  parameter int CLK_PER_TICK     = 4,
  parameter int GREEN_STEP_TICKS = 2,
  parameter int YELLOW_TICKS     = 3,
  parameter int WALK_TICKS       = 4,
  parameter int ALLRED_TICKS     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fault,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic       preempt,
`endif
  input  logic       ped_req,
  output logic [3:0] timing_state,
  output logic       ped_ack,
  output logic       cycle_done
);

  typedef enum logic [3:0] {
    S_NSG0   = 4'd0,
    S_NSG1   = 4'd1,
    S_NSG2   = 4'd2,
    S_NSG3   = 4'd3,
    S_NSY    = 4'd4,
    S_EWG0   = 4'd5,
    S_EWG1   = 4'd6,
    S_EWG2   = 4'd7,
    S_EWG3   = 4'd8,
    S_EWY    = 4'd9,
    S_WALK   = 4'd10,
    S_ALLRED = 4'd15
  } state_t;

  state_t      r_state;
  logic [15:0] r_presc;
  logic [7:0]  r_dwell;
  logic        r_pedLatch;
  logic        r_pedAck;
  logic        r_cycleDone;

  state_t      w_next;
  logic        w_tick;

  // Dwell counter reload value for a state being entered (counts down to zero, inclusive).
  function automatic logic [7:0] dwellLoad(input state_t s);
    case (s)
      S_NSY, S_EWY: dwellLoad = 8'(YELLOW_TICKS - 1);
      S_WALK:       dwellLoad = 8'(WALK_TICKS - 1);
      S_ALLRED:     dwellLoad = 8'(ALLRED_TICKS - 1);
      default:      dwellLoad = 8'(GREEN_STEP_TICKS - 1);
    endcase
  endfunction

  assign w_tick = (r_presc == 16'(CLK_PER_TICK - 1));

  always_comb begin
    w_next = S_ALLRED;
    case (r_state)
      S_NSG0:   w_next = S_NSG1;
      S_NSG1:   w_next = S_NSG2;
      S_NSG2:   w_next = S_NSG3;
      S_NSG3:   w_next = S_NSY;
      S_NSY:    w_next = S_EWG0;
      S_EWG0:   w_next = S_EWG1;
      S_EWG1:   w_next = S_EWG2;
      S_EWG2:   w_next = S_EWG3;
      S_EWG3:   w_next = S_EWY;
      S_EWY:    w_next = r_pedLatch ? S_WALK : S_NSG0;
      S_WALK:   w_next = S_NSG0;
      S_ALLRED: w_next = S_NSG0;
      default:  w_next = S_ALLRED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_ALLRED;
      r_presc     <= 16'd0;
      r_dwell     <= 8'(ALLRED_TICKS - 1);
      r_pedLatch  <= 1'b0;
      r_pedAck    <= 1'b0;
      r_cycleDone <= 1'b0;
    end else begin
      r_pedAck    <= 1'b0;
      r_cycleDone <= 1'b0;
      if (ped_req && r_state != S_WALK)
        r_pedLatch <= 1'b1;

      // Holding the counters at their entry values during fault makes release behave like reset release.
      if (fault) begin
        r_state <= S_ALLRED;
        r_presc <= 16'd0;
        r_dwell <= 8'(ALLRED_TICKS - 1);
      end
`ifdef TRAFFIC_PREEMPT_EN
      else if (preempt && r_state != S_NSY && r_state != S_EWY) begin
        r_presc <= 16'd0;
        case (r_state)
          S_NSG0, S_NSG1, S_NSG2, S_NSG3: begin
            r_state <= S_NSY;
            r_dwell <= 8'(YELLOW_TICKS - 1);
          end
          S_EWG0, S_EWG1, S_EWG2, S_EWG3: begin
            r_state <= S_EWY;
            r_dwell <= 8'(YELLOW_TICKS - 1);
          end
          default: begin
            r_state <= S_ALLRED;
            r_dwell <= 8'(ALLRED_TICKS - 1);
          end
        endcase
      end else if (preempt) begin
        if (enable) begin
          r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
          if (w_tick) begin
            if (r_dwell == 8'd0) begin
              r_state <= S_ALLRED;
              r_dwell <= 8'(ALLRED_TICKS - 1);
            end else begin
              r_dwell <= r_dwell - 8'd1;
            end
          end
        end
      end
`endif
      else if (enable) begin
        r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
        if (w_tick) begin
          if (r_dwell == 8'd0) begin
            r_state     <= w_next;
            r_dwell     <= dwellLoad(w_next);
            r_pedAck    <= (w_next == S_WALK);
            r_cycleDone <= (w_next == S_NSG0) && (r_state == S_EWY || r_state == S_WALK);
            // Placed after the set above so the clear wins on the 9->10 edge.
            if (r_state == S_EWY && w_next == S_WALK)
              r_pedLatch <= 1'b0;
          end else begin
            r_dwell <= r_dwell - 8'd1;
          end
        end
      end
    end
  end

  assign timing_state = r_state;
  assign ped_ack      = r_pedAck;
  assign cycle_done   = r_cycleDone;

endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
- Sequential controller that generates the 4-bit timing_state code consumed by the traffic-light decoder: 0-3 NS green, 4 NS yellow, 5-8 EW green, 9 EW yellow, 10 pedestrian walk, 15 all-red.
- Owns the tick prescaler, per-state dwell timing, pedestrian request latching/acknowledge, fault forcing and startup all-red.
- The decoder stays purely combinational; this block is its only driver.

Parameters:
- CLK_PER_TICK, 4, clocks per timing tick (1..65535, 16-bit prescaler).
- GREEN_STEP_TICKS, 2, dwell of each green sub-state 0-3 and 5-8 (1..255).
- YELLOW_TICKS, 3, dwell of states 4 and 9 (1..255).
- WALK_TICKS, 4, dwell of state 10 (1..255).
- ALLRED_TICKS, 2, dwell of startup/recovery state 15 (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = run; 0 = freeze prescaler, dwell counter and state.
- fault  in  1  1 = force all-red (state 15) immediately.
- ped_req  in  1  pedestrian button level/pulse, synchronous to clk.
- timing_state  out  4  registered state code to the decoder.
- ped_ack  out  1  one-cycle pulse on entry to state 10.
- cycle_done  out  1  one-cycle pulse on entry to state 0 from 9 or 10.

Behaviour:
- Reset (rst_n=0 at a clk edge): timing_state=15, ped_ack=0, cycle_done=0, ped latch=0, prescaler=0, dwell counter=ALLRED_TICKS-1.
- Tick: prescaler counts 0..CLK_PER_TICK-1 while enable=1. tick=1 when count==CLK_PER_TICK-1, then wraps to 0. Free-running across state changes. Cleared only by reset and fault release.
- Dwell: on every state entry, load DWELL(state)-1. On each tick, if counter==0 transition, else decrement. A state therefore lasts exactly DWELL×CLK_PER_TICK clocks.
- Transitions on dwell expiry:
  - 15->0
  - 0->1->2->3->4->5->6->7->8->9
  - 9->10 if ped latch=1, else 9->0
  - 10->0
- Ped latch:
  - Set on any cycle with ped_req=1 and timing_state!=10.
  - Cleared on the 9->10 transition cycle; clear wins over a simultaneous set.
  - ped_req during state 10 is ignored.
  - Preserved across fault.
- ped_ack and cycle_done are registered and assert the same cycle timing_state shows the new value.
- enable=0: all counters and state hold, pulses forced 0, ped latch still captures.
- fault=1:
  - Next edge sets timing_state=15, regardless of enable or current state.
  - Held while fault=1; no pulses are generated.
- Fault release (first cycle fault=0): prescaler=0, dwell=ALLRED_TICKS-1, then the normal 15->0 path.
- Priority: rst_n > fault > (PREEMPT if compiled) > enable/normal sequencing.
- timing_state never takes values 11-14. No output glitches; all outputs are flops.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN. When defined, adds input port preempt (1 bit, after fault).
- Preempt actions when preempt=1:
  - In 0-3: jump next edge to 4 with full YELLOW dwell.
  - In 5-8: jump to 9 with full YELLOW dwell.
  - In 4 or 9: finish the yellow dwell.
  - In 10: go directly to 15.
- After the yellow completes, go to 15 and hold while preempt=1, not 9->10 or 9->0.
- On preempt release, take the ALLRED_TICKS dwell in 15, then 0.
- The ped latch is not cleared by preempt.
- When not defined: no port and no logic.

Test Plan:
- Params 2/2/3/4/2, release reset, enable=1, no ped -> timing_state=15 for 4 clks, 0 after 4th edge. Full sequence 0..9 lasts 44 clks, cycle_done pulses once on 9->0, state 10 never appears.
- Pulse ped_req 1 clk during state 2 -> after 9, state 10 for 8 clks with ped_ack single pulse on entry, then 0 with cycle_done. Next cycle skips 10.
- Assert ped_req continuously through state 9->10 and during 10 -> latch clear wins, stays 0 during 10, next cycle 9->0.
- enable=0 for 10 clks mid-state 6 -> state and remaining dwell unchanged; total state-6 duration = 4+10 clks.
- fault=1 in state 7 for 5 clks -> state 15 next edge, held. After release, 15 for exactly 4 clks then 0; pending ped latch still served at next 9.
- TRAFFIC_PREEMPT_EN: preempt=1 in state 1 -> 4 next edge for 6 clks, then 15 held. Release -> 4 clks later state 0.
